// File: rtl/dmi_debug_module_pkg.sv
// rtl/dmi_debug_module_pkg.sv - dm_pkg: DMI register map, cmderr codes, abstract FSM states
package dm_pkg;

  localparam logic [6:0] DM_DATA0        = 7'h04;
  localparam logic [6:0] DM_DATA1        = 7'h05;
  localparam logic [6:0] DM_DMCONTROL    = 7'h10;
  localparam logic [6:0] DM_DMSTATUS     = 7'h11;
  localparam logic [6:0] DM_HARTINFO     = 7'h12;
  localparam logic [6:0] DM_ABSTRACTCS   = 7'h16;
  localparam logic [6:0] DM_COMMAND      = 7'h17;
  localparam logic [6:0] DM_ABSTRACTAUTO = 7'h18;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

  localparam logic [1:0] DMI_RESP_OK     = 2'b00;
  localparam logic [1:0] DMI_RESP_FAILED = 2'b10;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  typedef enum logic [1:0] {
    ABS_IDLE = 2'd0,
    ABS_XFER = 2'd1,
    ABS_DONE = 2'd2
  } abs_state_e;

endpackage

// File: rtl/dmi_debug_module_if.sv
// rtl/dmi_debug_module_if.sv - DMI request/response bus between jtag_dtm (master) and the debug module (slave)
interface dmi_debug_module_if;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [1:0]  dmi_op;
  logic        dmi_req;
  logic [31:0] dmi_rdata;
  logic [1:0]  dmi_resp;
  logic        dmi_ack;

  modport master (
    output dmi_addr, dmi_wdata, dmi_op, dmi_req,
    input  dmi_rdata, dmi_resp, dmi_ack
  );

  modport slave (
    input  dmi_addr, dmi_wdata, dmi_op, dmi_req,
    output dmi_rdata, dmi_resp, dmi_ack
  );
endinterface

// File: rtl/dmi_debug_module_abstract_fsm.sv
// rtl/dmi_debug_module_abstract_fsm.sv - dm_abstract_fsm: abstract command sequencing, ar_* port, busy and cmderr
module dm_abstract_fsm
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_cmd_wr,
  input  logic [7:0]  i_cmdtype,
  input  logic [2:0]  i_aarsize,
  input  logic        i_transfer,
  input  logic        i_write,
  input  logic [15:0] i_regno,
  input  logic        i_abscs_wr,
  input  logic [2:0]  i_cmderr_w1c,
  input  logic        i_data_wr,
  input  logic        i_autoexec,
  input  logic        i_hart_halted,
  input  logic [31:0] i_data0,
  input  logic        i_ar_ack,
  input  logic [31:0] i_ar_rdata,
  input  logic        i_ar_err,
  output logic        o_busy,
  output logic [2:0]  o_cmderr,
  output logic        o_data0_we,
  output logic [31:0] o_data0_wdata,
  output logic        o_ar_req,
  output logic        o_ar_write,
  output logic [15:0] o_ar_regno,
  output logic [31:0] o_ar_wdata
);

  abs_state_e  r_state;
  abs_state_e  w_state_nxt;
  logic [2:0]  r_cmderr;
  logic        r_write;
  logic        r_transfer;
  logic [15:0] r_regno;
  logic        w_busy;
  logic        w_issue;
  logic        w_notsup;
  logic        w_go;
  logic        w_start;
  logic        w_xfer_done;

  // An autoexec re-issue replays a command that already passed the format checks.
  assign w_busy      = (r_state != ABS_IDLE);
  assign w_issue     = !w_busy && (r_cmderr == CMDERR_NONE) && (i_cmd_wr || i_autoexec);
  assign w_notsup    = i_cmd_wr && ((i_cmdtype != 8'd0) || (i_aarsize != 3'd2));
  assign w_go        = w_issue && !w_notsup && i_hart_halted;
  assign w_start     = w_go && (i_cmd_wr ? i_transfer : r_transfer);
  assign w_xfer_done = (r_state == ABS_XFER) && i_ar_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ABS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ABS_IDLE;
    end else begin
      case (r_state)
        ABS_IDLE: if (w_start) w_state_nxt = ABS_XFER;
        ABS_XFER: if (i_ar_ack) w_state_nxt = ABS_DONE;
        ABS_DONE: w_state_nxt = ABS_IDLE;
        default:  w_state_nxt = ABS_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy        = w_busy;
    o_cmderr      = r_cmderr;
    o_ar_req      = (r_state == ABS_XFER);
    o_ar_write    = o_ar_req && r_write;
    o_ar_regno    = o_ar_req ? r_regno : 16'd0;
    o_ar_wdata    = o_ar_req ? i_data0 : 32'd0;
    o_data0_we    = w_xfer_done && !i_ar_err && !r_write && !i_clear;
    o_data0_wdata = i_ar_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmderr <= CMDERR_NONE;
    end else if (i_clear) begin
      r_cmderr <= CMDERR_NONE;
    end else if (w_xfer_done && i_ar_err) begin
      r_cmderr <= CMDERR_EXCEPTION;
    end else if (w_busy && (i_cmd_wr || i_abscs_wr || i_data_wr)) begin
      if (r_cmderr == CMDERR_NONE) r_cmderr <= CMDERR_BUSY;
    end else if (i_abscs_wr) begin
      r_cmderr <= r_cmderr & ~i_cmderr_w1c;
    end else if (w_issue && w_notsup) begin
      r_cmderr <= CMDERR_NOTSUP;
    end else if (w_issue && !i_hart_halted) begin
      r_cmderr <= CMDERR_HALTRESUME;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_transfer <= 1'b0;
      r_regno    <= 16'd0;
    end else if (i_clear) begin
      r_write    <= 1'b0;
      r_transfer <= 1'b0;
      r_regno    <= 16'd0;
    end else if (w_go && i_cmd_wr) begin
      r_write    <= i_write;
      r_transfer <= i_transfer;
      r_regno    <= i_regno;
    end
  end

endmodule

// File: rtl/dmi_debug_module.sv
// rtl/dmi_debug_module.sv - RISC-V Debug Module DMI target: decode, dmcontrol/dmstatus, data registers
// Optional abstractauto register (0x18) built when DM_AUTOEXEC_EN is defined.
module dmi_debug_module
  import dm_pkg::*;
#(
  parameter logic [31:0] HARTINFO  = 32'h0,
  parameter int          DATACOUNT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dmi_debug_module_if.slave    dmi,
  output logic                 halt_req,
  output logic                 resume_req,
  output logic                 ndmreset,
  input  logic                 hart_halted,
  input  logic                 hart_running,
  output logic                 ar_req,
  output logic                 ar_write,
  output logic [15:0]          ar_regno,
  output logic [31:0]          ar_wdata,
  input  logic [31:0]          ar_rdata,
  input  logic                 ar_ack,
  input  logic                 ar_err
);

  localparam logic [3:0] DATACOUNT_F = 4'(DATACOUNT);
  localparam bit         HAS_DATA1   = (DATACOUNT >= 2);

  logic        r_ack;
  logic [1:0]  r_resp;
  logic [31:0] r_rdata;
  logic        r_dmactive;
  logic        r_haltreq;
  logic        r_ndmreset;
  logic        r_resume_req;
  logic        r_resumeack;
  logic [31:0] r_data0;
  logic [31:0] r_data1;

  logic        w_rd;
  logic        w_wr;
  logic        w_ctl_wr;
  logic        w_clear;
  logic        w_act_wr;
  logic        w_cmd_wr;
  logic        w_abscs_wr;
  logic        w_data_wr;
  logic        w_resume_set;
  logic        w_autoexec;
  logic        w_busy;
  logic [2:0]  w_cmderr;
  logic        w_data0_we;
  logic [31:0] w_data0_wdata;
  logic [31:0] w_rd_data;

  assign w_rd       = dmi.dmi_req && (dmi.dmi_op == DMI_OP_READ);
  assign w_wr       = dmi.dmi_req && (dmi.dmi_op == DMI_OP_WRITE);
  assign w_ctl_wr   = w_wr && (dmi.dmi_addr == DM_DMCONTROL);
  // Everything but dmactive stays in reset while inactive or being deactivated.
  assign w_clear    = !r_dmactive || (w_ctl_wr && !dmi.dmi_wdata[0]);
  assign w_act_wr   = w_wr && r_dmactive;
  assign w_cmd_wr   = w_act_wr && (dmi.dmi_addr == DM_COMMAND);
  assign w_abscs_wr = w_act_wr && (dmi.dmi_addr == DM_ABSTRACTCS);
  assign w_data_wr  = w_act_wr && ((dmi.dmi_addr == DM_DATA0) ||
                                   (HAS_DATA1 && (dmi.dmi_addr == DM_DATA1)));
  assign w_resume_set = w_ctl_wr && r_dmactive && dmi.dmi_wdata[0] && dmi.dmi_wdata[30] &&
                        !dmi.dmi_wdata[31] && hart_halted;

  assign dmi.dmi_ack   = r_ack;
  assign dmi.dmi_resp  = r_resp;
  assign dmi.dmi_rdata = r_rdata;
  assign halt_req      = r_haltreq && r_dmactive;
  assign resume_req    = r_resume_req;
  assign ndmreset      = r_ndmreset;

`ifdef DM_AUTOEXEC_EN
  logic r_autoexec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_autoexec <= 1'b0;
    end else if (w_clear) begin
      r_autoexec <= 1'b0;
    end else if (w_act_wr && (dmi.dmi_addr == DM_ABSTRACTAUTO)) begin
      r_autoexec <= dmi.dmi_wdata[0];
    end
  end

  assign w_autoexec = r_autoexec && r_dmactive && (w_rd || w_wr) && (dmi.dmi_addr == DM_DATA0);
`else
  assign w_autoexec = 1'b0;
`endif

  always_comb begin
    w_rd_data = 32'd0;
    case (dmi.dmi_addr)
      DM_DATA0:      w_rd_data = r_data0;
      DM_DATA1:      if (HAS_DATA1) w_rd_data = r_data1;
      DM_DMCONTROL:  w_rd_data = {r_haltreq, 29'd0, r_ndmreset, r_dmactive};
      DM_DMSTATUS:   w_rd_data = {14'd0, {2{r_resumeack}}, 4'd0, {2{hart_running}},
                                  {2{hart_halted}}, 1'b1, 3'd0, 4'd2};
      DM_HARTINFO:   w_rd_data = HARTINFO;
      DM_ABSTRACTCS: w_rd_data = {19'd0, w_busy, 1'b0, w_cmderr, 4'd0, DATACOUNT_F};
`ifdef DM_AUTOEXEC_EN
      DM_ABSTRACTAUTO: w_rd_data = {31'd0, r_autoexec};
`endif
      default:       w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_resp  <= DMI_RESP_OK;
      r_rdata <= 32'd0;
    end else begin
      r_ack <= dmi.dmi_req;
      if (dmi.dmi_req) begin
        r_resp <= (dmi.dmi_op == DMI_OP_RSVD) ? DMI_RESP_FAILED : DMI_RESP_OK;
      end
      if (w_rd) r_rdata <= w_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmactive <= 1'b0;
      r_haltreq  <= 1'b0;
      r_ndmreset <= 1'b0;
    end else begin
      if (w_ctl_wr) r_dmactive <= dmi.dmi_wdata[0];
      if (w_clear) begin
        r_haltreq  <= 1'b0;
        r_ndmreset <= 1'b0;
      end else if (w_ctl_wr) begin
        r_haltreq  <= dmi.dmi_wdata[31];
        r_ndmreset <= dmi.dmi_wdata[1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resume_req <= 1'b0;
      r_resumeack  <= 1'b0;
    end else if (w_clear) begin
      r_resume_req <= 1'b0;
      r_resumeack  <= 1'b0;
    end else if (w_resume_set) begin
      r_resume_req <= 1'b1;
      r_resumeack  <= 1'b0;
    end else if (r_resume_req && hart_running) begin
      r_resume_req <= 1'b0;
      r_resumeack  <= 1'b1;
    end
  end

  // Data writes while busy are dropped; the FSM flags them as cmderr=BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data0 <= 32'd0;
      r_data1 <= 32'd0;
    end else if (w_clear) begin
      r_data0 <= 32'd0;
      r_data1 <= 32'd0;
    end else begin
      if (w_data0_we) begin
        r_data0 <= w_data0_wdata;
      end else if (w_data_wr && !w_busy && (dmi.dmi_addr == DM_DATA0)) begin
        r_data0 <= dmi.dmi_wdata;
      end
      if (w_data_wr && !w_busy && (dmi.dmi_addr == DM_DATA1)) begin
        r_data1 <= dmi.dmi_wdata;
      end
    end
  end

  dm_abstract_fsm u_abstract_fsm (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_clear),
    .i_cmd_wr      (w_cmd_wr),
    .i_cmdtype     (dmi.dmi_wdata[31:24]),
    .i_aarsize     (dmi.dmi_wdata[22:20]),
    .i_transfer    (dmi.dmi_wdata[17]),
    .i_write       (dmi.dmi_wdata[16]),
    .i_regno       (dmi.dmi_wdata[15:0]),
    .i_abscs_wr    (w_abscs_wr),
    .i_cmderr_w1c  (dmi.dmi_wdata[10:8]),
    .i_data_wr     (w_data_wr),
    .i_autoexec    (w_autoexec),
    .i_hart_halted (hart_halted),
    .i_data0       (r_data0),
    .i_ar_ack      (ar_ack),
    .i_ar_rdata    (ar_rdata),
    .i_ar_err      (ar_err),
    .o_busy        (w_busy),
    .o_cmderr      (w_cmderr),
    .o_data0_we    (w_data0_we),
    .o_data0_wdata (w_data0_wdata),
    .o_ar_req      (ar_req),
    .o_ar_write    (ar_write),
    .o_ar_regno    (ar_regno),
    .o_ar_wdata    (ar_wdata)
  );

endmodule

// File: tb/tb_dmi_debug_module.sv
// tb/tb_dmi_debug_module.sv - directed vector bench for dmi_debug_module
module tb_dmi_debug_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_req, resume_req, ndmreset;
  logic        hart_halted, hart_running;
  logic        ar_req, ar_write;
  logic [15:0] ar_regno;
  logic [31:0] ar_wdata, ar_rdata;
  logic        ar_ack, ar_err;

  int n_checks = 0;
  int n_fail   = 0;

  dmi_debug_module_if dmi();

  dmi_debug_module #(.HARTINFO(32'h0), .DATACOUNT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .dmi          (dmi),
    .halt_req     (halt_req),
    .resume_req   (resume_req),
    .ndmreset     (ndmreset),
    .hart_halted  (hart_halted),
    .hart_running (hart_running),
    .ar_req       (ar_req),
    .ar_write     (ar_write),
    .ar_regno     (ar_regno),
    .ar_wdata     (ar_wdata),
    .ar_rdata     (ar_rdata),
    .ar_ack       (ar_ack),
    .ar_err       (ar_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                              input logic chk, input logic [31:0] erd, input logic [1:0] ersp);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.chk_rd = chk; v.exp_rd = erd; v.exp_resp = ersp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge two cycles later with the bus idle.
  task automatic dmi_xact(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [1:0] rsp);
    dmi.dmi_req = 1'b1; dmi.dmi_op = op; dmi.dmi_addr = addr; dmi.dmi_wdata = wd;
    @(negedge clk);
    check("ack_high", {31'd0, dmi.dmi_ack}, 32'd1);
    rd  = dmi.dmi_rdata;
    rsp = dmi.dmi_resp;
    dmi.dmi_req = 1'b0; dmi.dmi_op = 2'd0;
    @(negedge clk);
    check("ack_low", {31'd0, dmi.dmi_ack}, 32'd0);
  endtask

  task automatic rd_expect(input string name, input logic [6:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic [1:0]  rsp;
    dmi_xact(2'd1, addr, 32'd0, rd, rsp);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic [1:0]  rsp;
    dmi_xact(2'd2, addr, wd, rd, rsp);
  endtask

  task automatic wait_ar_req(input string name);
    for (int k = 0; k < 20 && !ar_req; k++) @(negedge clk);
    check(name, {31'd0, ar_req}, 32'd1);
  endtask

  // ar_ack after three cycles; returns with the FSM back in IDLE.
  task automatic ar_complete(input logic [31:0] rdata, input logic err);
    repeat (3) @(negedge clk);
    ar_ack = 1'b1; ar_rdata = rdata; ar_err = err;
    @(negedge clk);
    ar_ack = 1'b0; ar_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    dmi.dmi_req = 1'b0; dmi.dmi_op = 2'd0; dmi.dmi_addr = 7'd0; dmi.dmi_wdata = 32'd0;
    hart_halted = 1'b0; hart_running = 1'b0;
    ar_rdata = 32'd0; ar_ack = 1'b0; ar_err = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack",        {31'd0, dmi.dmi_ack}, 32'd0);
    check("rst_rdata",      dmi.dmi_rdata, 32'd0);
    check("rst_halt_req",   {31'd0, halt_req}, 32'd0);
    check("rst_resume_req", {31'd0, resume_req}, 32'd0);
    check("rst_ndmreset",   {31'd0, ndmreset}, 32'd0);
    check("rst_ar_req",     {31'd0, ar_req}, 32'd0);

    vecs.push_back(mk(2'd1, 7'h11, 32'h0,        1'b1, 32'h0000_0082, 2'b00));
    vecs.push_back(mk(2'd1, 7'h10, 32'h0,        1'b1, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(2'd2, 7'h10, 32'h8000_0001, 1'b0, 32'h0,        2'b00));
    vecs.push_back(mk(2'd1, 7'h10, 32'h0,        1'b1, 32'h0000_0001, 2'b00));
    vecs.push_back(mk(2'd1, 7'h16, 32'h0,        1'b1, 32'h0000_0002, 2'b00));
    vecs.push_back(mk(2'd1, 7'h12, 32'h0,        1'b1, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(2'd2, 7'h04, 32'h1234_5678, 1'b0, 32'h0,        2'b00));
    vecs.push_back(mk(2'd1, 7'h04, 32'h0,        1'b1, 32'h1234_5678, 2'b00));
    vecs.push_back(mk(2'd2, 7'h05, 32'hA5A5_A5A5, 1'b0, 32'h0,        2'b00));
    vecs.push_back(mk(2'd1, 7'h05, 32'h0,        1'b1, 32'hA5A5_A5A5, 2'b00));
    vecs.push_back(mk(2'd3, 7'h04, 32'hFFFF_FFFF, 1'b1, 32'hA5A5_A5A5, 2'b10));
    vecs.push_back(mk(2'd1, 7'h04, 32'h0,        1'b1, 32'h1234_5678, 2'b00));
    vecs.push_back(mk(2'd0, 7'h05, 32'h0,        1'b1, 32'h1234_5678, 2'b00));
    vecs.push_back(mk(2'd2, 7'h40, 32'hFFFF_FFFF, 1'b0, 32'h0,        2'b00));
    vecs.push_back(mk(2'd1, 7'h40, 32'h0,        1'b1, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(2'd1, 7'h18, 32'h0,        1'b1, 32'h0000_0000, 2'b00));
    vecs.push_back(mk(2'd2, 7'h11, 32'hFFFF_FFFF, 1'b0, 32'h0,        2'b00));
    vecs.push_back(mk(2'd1, 7'h11, 32'h0,        1'b1, 32'h0000_0082, 2'b00));
    vecs.push_back(mk(2'd2, 7'h12, 32'hFFFF_FFFF, 1'b0, 32'h0,        2'b00));
    vecs.push_back(mk(2'd1, 7'h12, 32'h0,        1'b1, 32'h0000_0000, 2'b00));

    foreach (vecs[i]) begin
      dmi_xact(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, rsp);
      check($sformatf("vec%0d_resp", i), {30'd0, rsp}, {30'd0, vecs[i].exp_resp});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    check("haltreq_ignored_inactive", {31'd0, halt_req}, 32'd0);

    // back-to-back: second request presented while first ack is high
    dmi.dmi_req = 1'b1; dmi.dmi_op = 2'd1; dmi.dmi_addr = 7'h11;
    @(negedge clk);
    check("b2b_ack1", {31'd0, dmi.dmi_ack}, 32'd1);
    check("b2b_rd1", dmi.dmi_rdata, 32'h0000_0082);
    dmi.dmi_addr = 7'h16;
    @(negedge clk);
    check("b2b_ack2", {31'd0, dmi.dmi_ack}, 32'd1);
    check("b2b_rd2", dmi.dmi_rdata, 32'h0000_0002);
    dmi.dmi_req = 1'b0; dmi.dmi_op = 2'd0;
    @(negedge clk);
    check("b2b_ack_low", {31'd0, dmi.dmi_ack}, 32'd0);

    // halt / resume
    wr(7'h10, 32'h8000_0001);
    check("halt_req_set", {31'd0, halt_req}, 32'd1);
    hart_halted = 1'b1;
    @(negedge clk);
    rd_expect("dmstatus_halted", 7'h11, 32'h0000_0382);
    wr(7'h10, 32'h8000_0003);
    check("ndmreset_set", {31'd0, ndmreset}, 32'd1);
    rd_expect("dmcontrol_rb", 7'h10, 32'h8000_0003);
    wr(7'h10, 32'h4000_0001);
    check("resume_req_set", {31'd0, resume_req}, 32'd1);
    check("halt_req_clr", {31'd0, halt_req}, 32'd0);
    check("ndmreset_clr", {31'd0, ndmreset}, 32'd0);
    repeat (5) @(negedge clk);
    check("resume_req_hold", {31'd0, resume_req}, 32'd1);
    hart_halted = 1'b0; hart_running = 1'b1;
    @(negedge clk);
    check("resume_req_drop", {31'd0, resume_req}, 32'd0);
    rd_expect("dmstatus_running", 7'h11, 32'h0003_0C82);
    wr(7'h10, 32'h4000_0001);
    check("resume_ignored_running", {31'd0, resume_req}, 32'd0);
    hart_running = 1'b0; hart_halted = 1'b1;
    @(negedge clk);

    // abstract read of x5
    wr(7'h17, 32'h0022_1005);
    wait_ar_req("rd_ar_req");
    check("rd_ar_regno", {16'd0, ar_regno}, 32'h0000_1005);
    check("rd_ar_write", {31'd0, ar_write}, 32'd0);
    rd_expect("abscs_busy", 7'h16, 32'h0000_1002);
    ar_complete(32'hCAFE_BABE, 1'b0);
    check("rd_ar_req_drop", {31'd0, ar_req}, 32'd0);
    rd_expect("data0_cafebabe", 7'h04, 32'hCAFE_BABE);
    rd_expect("abscs_idle", 7'h16, 32'h0000_0002);

    // command while busy -> cmderr=1, then W1C
    wr(7'h17, 32'h0022_1005);
    wait_ar_req("busy_ar_req");
    wr(7'h17, 32'h0022_1006);
    rd_expect("abscs_cmderr_busy", 7'h16, 32'h0000_1102);
    ar_complete(32'h1111_1111, 1'b0);
    rd_expect("abscs_cmderr1_idle", 7'h16, 32'h0000_0102);
    wr(7'h17, 32'h0022_1005);
    check("cmd_blocked_by_cmderr", {31'd0, ar_req}, 32'd0);
    wr(7'h16, 32'h0000_0700);
    rd_expect("abscs_cleared", 7'h16, 32'h0000_0002);

    // ar_err -> cmderr=3, data0 untouched
    wr(7'h17, 32'h0022_1005);
    wait_ar_req("err_ar_req");
    ar_complete(32'hDEAD_BEEF, 1'b1);
    rd_expect("abscs_exception", 7'h16, 32'h0000_0302);
    rd_expect("data0_kept", 7'h04, 32'h1111_1111);
    wr(7'h16, 32'h0000_0700);

    // abstract write of x7 from data0
    wr(7'h04, 32'h55AA_55AA);
    wr(7'h17, 32'h0023_1007);
    wait_ar_req("wr_ar_req");
    check("wr_ar_write", {31'd0, ar_write}, 32'd1);
    check("wr_ar_wdata", ar_wdata, 32'h55AA_55AA);
    check("wr_ar_regno", {16'd0, ar_regno}, 32'h0000_1007);
    ar_complete(32'h0, 1'b0);
    rd_expect("data0_after_write", 7'h04, 32'h55AA_55AA);

    // not halted -> cmderr=4
    hart_halted = 1'b0;
    wr(7'h17, 32'h0022_1005);
    check("haltresume_no_req", {31'd0, ar_req}, 32'd0);
    rd_expect("abscs_haltresume", 7'h16, 32'h0000_0402);
    wr(7'h16, 32'h0000_0700);
    hart_halted = 1'b1;

    // aarsize=3 -> cmderr=2
    wr(7'h17, 32'h0032_1005);
    check("notsup_no_req", {31'd0, ar_req}, 32'd0);
    rd_expect("abscs_notsup", 7'h16, 32'h0000_0202);
    wr(7'h16, 32'h0000_0700);

    // transfer=0 completes immediately
    wr(7'h17, 32'h0020_1005);
    check("notransfer_no_req", {31'd0, ar_req}, 32'd0);
    rd_expect("abscs_notransfer", 7'h16, 32'h0000_0002);

    // deactivate during XFER
    wr(7'h05, 32'h0BAD_F00D);
    wr(7'h17, 32'h0022_1005);
    wait_ar_req("deact_ar_req");
    dmi.dmi_req = 1'b1; dmi.dmi_op = 2'd2; dmi.dmi_addr = 7'h10; dmi.dmi_wdata = 32'h0;
    @(negedge clk);
    check("deact_ack", {31'd0, dmi.dmi_ack}, 32'd1);
    check("deact_ar_req_drop", {31'd0, ar_req}, 32'd0);
    dmi.dmi_req = 1'b0; dmi.dmi_op = 2'd0;
    @(negedge clk);
    wr(7'h10, 32'h0000_0001);
    rd_expect("react_data0", 7'h04, 32'h0);
    rd_expect("react_data1", 7'h05, 32'h0);
    rd_expect("react_abscs", 7'h16, 32'h0000_0002);
    rd_expect("react_dmcontrol", 7'h10, 32'h0000_0001);
    rd_expect("react_dmstatus", 7'h11, 32'h0000_0382);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1);
  end

endmodule
